// File: rtl/hilo_acc_pkg.sv
// Shared definitions for the HI/LO accumulator: op codes, FSM states and
// small decode helpers used by the top and the bench.
package hilo_acc_pkg;

   localparam int HILO_DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      HILO_OP_WRITE   = 2'b00,
      HILO_OP_ACC_ADD = 2'b01,
      HILO_OP_ACC_SUB = 2'b10,
      HILO_OP_RSVD    = 2'b11
   } hilo_op_e;

   typedef enum logic [1:0] {
      HILO_ST_IDLE   = 2'd0,
      HILO_ST_ACC_LO = 2'd1,
      HILO_ST_ACC_HI = 2'd2
   } hilo_state_e;

   function automatic logic hilo_is_acc(input logic [1:0] op);
      return (op == HILO_OP_ACC_ADD) || (op == HILO_OP_ACC_SUB);
   endfunction

   function automatic logic hilo_is_sub(input logic [1:0] op);
      return (op == HILO_OP_ACC_SUB);
   endfunction

endpackage

// File: rtl/hilo_acc_if.sv
// Request/response bundle for hilo_acc. valid_i/ready_o: a request is taken on
// a rising edge where valid_i && ready_o && !flush_i; an unaccepted valid_i is dropped.
interface hilo_acc_if
   import hilo_acc_pkg::*;
#(
   parameter int DATA_W = HILO_DATA_W_DEF
);
   logic              valid_i;
   logic [1:0]        op_i;
   logic              hi_we;
   logic              lo_we;
   logic [DATA_W-1:0] hi_i;
   logic [DATA_W-1:0] lo_i;
   logic              flush_i;
   logic              ready_o;
   logic              busy_o;
   logic              done_o;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;
   hilo_state_e       dbg_state_o;

   modport slave (
      input  valid_i, op_i, hi_we, lo_we, hi_i, lo_i, flush_i,
      output ready_o, busy_o, done_o, hi_o, lo_o, dbg_state_o
   );

   modport master (
      output valid_i, op_i, hi_we, lo_we, hi_i, lo_i, flush_i,
      input  ready_o, busy_o, done_o, hi_o, lo_o, dbg_state_o
   );
endinterface

// File: rtl/hilo_addsub.sv
// DATA_W-bit adder/subtractor; subtract inverts b and relies on cin_i for the +1,
// so cout_o is the carry for ADD and the not-borrow for SUB.
module hilo_addsub #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              sub_i,
   input  logic              cin_i,
   output logic [DATA_W-1:0] sum_o,
   output logic              cout_o
);
   logic [DATA_W-1:0] b_eff;

   assign b_eff = sub_i ? ~b_i : b_i;
   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_i};
endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with WRITE and a two-stage 2*DATA_W accumulate.
// Optional HILO_WRITE_BYPASS_EN forwards accepted WRITE data to hi_o/lo_o.
module hilo_acc
   import hilo_acc_pkg::*;
#(
   parameter int DATA_W = HILO_DATA_W_DEF
) (
   input logic        clk,
   input logic        rst,
   hilo_acc_if.slave  bus
);
   hilo_state_e       state_q, state_d;
   logic              op_sub_q, op_sub_d;
   logic [DATA_W-1:0] opnd_hi_q, opnd_hi_d;
   logic [DATA_W-1:0] opnd_lo_q, opnd_lo_d;
   logic [DATA_W-1:0] temp_q, temp_d;
   logic              carry_q, carry_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   logic              idle;
   logic              accept;
   logic              wr_accept;
   logic              acc_accept;

   logic [DATA_W-1:0] as_a, as_b, as_sum;
   logic              as_cin, as_cout;

   assign idle       = (state_q == HILO_ST_IDLE);
   assign accept     = bus.valid_i && idle && !bus.flush_i;
   assign wr_accept  = accept && (bus.op_i == HILO_OP_WRITE);
   assign acc_accept = accept && hilo_is_acc(bus.op_i);

   // One adder serves both halves: LO stage in ACC_LO, HI stage in ACC_HI.
   hilo_addsub #(.DATA_W(DATA_W)) u_addsub (
      .a_i    (as_a),
      .b_i    (as_b),
      .sub_i  (op_sub_q),
      .cin_i  (as_cin),
      .sum_o  (as_sum),
      .cout_o (as_cout)
   );

   always_comb begin
      state_d   = state_q;
      op_sub_d  = op_sub_q;
      opnd_hi_d = opnd_hi_q;
      opnd_lo_d = opnd_lo_q;
      temp_d    = temp_q;
      carry_d   = carry_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      as_a      = lo_q;
      as_b      = opnd_lo_q;
      as_cin    = op_sub_q;

      case (state_q)
         HILO_ST_IDLE: begin
            if (wr_accept) begin
               if (bus.hi_we) hi_d = bus.hi_i;
               if (bus.lo_we) lo_d = bus.lo_i;
            end else if (acc_accept) begin
               opnd_hi_d = bus.hi_i;
               opnd_lo_d = bus.lo_i;
               op_sub_d  = hilo_is_sub(bus.op_i);
               state_d   = HILO_ST_ACC_LO;
            end
         end
         HILO_ST_ACC_LO: begin
            if (bus.flush_i) begin
               state_d = HILO_ST_IDLE;
            end else begin
               temp_d  = as_sum;
               carry_d = as_cout;
               state_d = HILO_ST_ACC_HI;
            end
         end
         HILO_ST_ACC_HI: begin
            as_a   = hi_q;
            as_b   = opnd_hi_q;
            as_cin = carry_q;
            if (bus.flush_i) begin
               state_d = HILO_ST_IDLE;
            end else begin
               hi_d    = as_sum;
               lo_d    = temp_q;
               state_d = HILO_ST_IDLE;
            end
         end
         default: state_d = HILO_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= HILO_ST_IDLE;
         op_sub_q  <= 1'b0;
         opnd_hi_q <= '0;
         opnd_lo_q <= '0;
         temp_q    <= '0;
         carry_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         op_sub_q  <= op_sub_d;
         opnd_hi_q <= opnd_hi_d;
         opnd_lo_q <= opnd_lo_d;
         temp_q    <= temp_d;
         carry_q   <= carry_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Outputs are forced to their reset values while rst is asserted.
   assign bus.ready_o     = rst || idle;
   assign bus.busy_o      = !(rst || idle);
   assign bus.done_o      = !rst && (state_q == HILO_ST_ACC_HI) && !bus.flush_i;
   assign bus.dbg_state_o = state_q;

`ifdef HILO_WRITE_BYPASS_EN
   assign bus.hi_o = rst ? '0 : ((wr_accept && bus.hi_we) ? bus.hi_i : hi_q);
   assign bus.lo_o = rst ? '0 : ((wr_accept && bus.lo_we) ? bus.lo_i : lo_q);
`else
   assign bus.hi_o = rst ? '0 : hi_q;
   assign bus.lo_o = rst ? '0 : lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// Directed bench for hilo_acc (DATA_W=32): write, add/sub, wrap, flush, reset, hold-while-busy.
module tb_hilo_acc;
   import hilo_acc_pkg::*;

   localparam int W = 32;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   hilo_acc_if #(.DATA_W(W)) bus ();

   hilo_acc #(.DATA_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic hwe, input logic lwe,
                        input logic [W-1:0] hi, input logic [W-1:0] lo);
      bus.valid_i = v;
      bus.op_i    = op;
      bus.hi_we   = hwe;
      bus.lo_we   = lwe;
      bus.hi_i    = hi;
      bus.lo_i    = lo;
   endtask

   task automatic quiet();
      drive(1'b0, 2'b00, 1'b0, 1'b0, '0, '0);
      bus.flush_i = 1'b0;
   endtask

   task automatic do_write(input logic [W-1:0] hi, input logic [W-1:0] lo);
      drive(1'b1, HILO_OP_WRITE, 1'b1, 1'b1, hi, lo);
      tick();
      quiet();
   endtask

   // Issue an accumulate and let it run through commit.
   task automatic do_acc(input logic [1:0] op, input logic [W-1:0] hi, input logic [W-1:0] lo);
      drive(1'b1, op, 1'b0, 1'b0, hi, lo);
      tick();
      quiet();
      tick();
      tick();
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      quiet();
      drive(1'b1, HILO_OP_ACC_ADD, 1'b1, 1'b1, 32'h5, 32'h5);
      tick();
      tick();
      #1;
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_hi", bus.hi_o, 0);
      chk("rst_lo", bus.lo_o, 0);
      rst = 1'b0;
      quiet();
      tick();

      // WRITE HI only
      drive(1'b1, HILO_OP_WRITE, 1'b1, 1'b0, 32'h1234, 32'hFFFF);
      #1;
      chk("wr_ready", bus.ready_o, 1);
`ifdef HILO_WRITE_BYPASS_EN
      chk("wr_hi_same_cycle", bus.hi_o, 32'h1234);
`else
      chk("wr_hi_same_cycle", bus.hi_o, 0);
`endif
      chk("wr_lo_same_cycle", bus.lo_o, 0);
      tick();
      quiet();
      #1;
      chk("wr_hi", bus.hi_o, 32'h1234);
      chk("wr_lo", bus.lo_o, 0);

      // ACC_ADD 0:FFFFFFFF + 0:1, stepwise
      do_write(32'h0, 32'hFFFF_FFFF);
      drive(1'b1, HILO_OP_ACC_ADD, 1'b0, 1'b0, 32'h0, 32'h1);
      #1;
      chk("add_ready_accept", bus.ready_o, 1);
      tick();
      quiet();
      #1;
      chk("add_lo_ready", bus.ready_o, 0);
      chk("add_lo_busy", bus.busy_o, 1);
      chk("add_lo_done", bus.done_o, 0);
      chk("add_lo_state", bus.dbg_state_o, HILO_ST_ACC_LO);
      chk("add_lo_hold_lo", bus.lo_o, 32'hFFFF_FFFF);
      tick();
      #1;
      chk("add_hi_ready", bus.ready_o, 0);
      chk("add_hi_done", bus.done_o, 1);
      chk("add_hi_state", bus.dbg_state_o, HILO_ST_ACC_HI);
      chk("add_hi_hold_hi", bus.hi_o, 0);
      tick();
      #1;
      chk("add_end_ready", bus.ready_o, 1);
      chk("add_end_done", bus.done_o, 0);
      chk("add_hi", bus.hi_o, 32'h1);
      chk("add_lo", bus.lo_o, 32'h0);

      // ACC_SUB 0:0 - 0:1
      do_write(32'h0, 32'h0);
      do_acc(HILO_OP_ACC_SUB, 32'h0, 32'h1);
      #1;
      chk("sub_hi", bus.hi_o, 32'hFFFF_FFFF);
      chk("sub_lo", bus.lo_o, 32'hFFFF_FFFF);

      // Wrap: FFFFFFFF:FFFFFFFF + 2:80000000 = 2:7FFFFFFF
      do_acc(HILO_OP_ACC_ADD, 32'h2, 32'h8000_0000);
      #1;
      chk("wrap_hi", bus.hi_o, 32'h2);
      chk("wrap_lo", bus.lo_o, 32'h7FFF_FFFF);

      // 5:0 - 1:1 = 3:FFFFFFFF
      do_write(32'h5, 32'h0);
      do_acc(HILO_OP_ACC_SUB, 32'h1, 32'h1);
      #1;
      chk("sub2_hi", bus.hi_o, 32'h3);
      chk("sub2_lo", bus.lo_o, 32'hFFFF_FFFF);

      // Flush in ACC_LO
      drive(1'b1, HILO_OP_ACC_ADD, 1'b0, 1'b0, 32'h0, 32'h1);
      tick();
      quiet();
      bus.flush_i = 1'b1;
      #1;
      chk("flo_done", bus.done_o, 0);
      chk("flo_busy", bus.busy_o, 1);
      tick();
      bus.flush_i = 1'b0;
      #1;
      chk("flo_ready", bus.ready_o, 1);
      chk("flo_hi", bus.hi_o, 32'h3);
      chk("flo_lo", bus.lo_o, 32'hFFFF_FFFF);

      // Flush in ACC_HI
      drive(1'b1, HILO_OP_ACC_ADD, 1'b0, 1'b0, 32'h0, 32'h1);
      tick();
      quiet();
      tick();
      bus.flush_i = 1'b1;
      #1;
      chk("fhi_done", bus.done_o, 0);
      tick();
      bus.flush_i = 1'b0;
      #1;
      chk("fhi_ready", bus.ready_o, 1);
      chk("fhi_hi", bus.hi_o, 32'h3);
      chk("fhi_lo", bus.lo_o, 32'hFFFF_FFFF);

      // Flush in IDLE blocks a WRITE
      drive(1'b1, HILO_OP_WRITE, 1'b1, 1'b1, 32'h9, 32'h9);
      bus.flush_i = 1'b1;
      tick();
      quiet();
      #1;
      chk("fidle_hi", bus.hi_o, 32'h3);
      chk("fidle_lo", bus.lo_o, 32'hFFFF_FFFF);
      chk("fidle_state", bus.dbg_state_o, HILO_ST_IDLE);

      // Reserved op
      drive(1'b1, HILO_OP_RSVD, 1'b1, 1'b1, 32'h7, 32'h7);
      tick();
      quiet();
      #1;
      chk("rsvd_ready", bus.ready_o, 1);
      chk("rsvd_hi", bus.hi_o, 32'h3);
      chk("rsvd_lo", bus.lo_o, 32'hFFFF_FFFF);

      // Reset in ACC_HI
      drive(1'b1, HILO_OP_ACC_ADD, 1'b0, 1'b0, 32'h0, 32'h1);
      tick();
      quiet();
      tick();
      rst = 1'b1;
      #1;
      chk("rstmid_done", bus.done_o, 0);
      chk("rstmid_ready", bus.ready_o, 1);
      tick();
      rst = 1'b0;
      #1;
      chk("rstmid_hi", bus.hi_o, 0);
      chk("rstmid_lo", bus.lo_o, 0);
      chk("rstmid_state", bus.dbg_state_o, HILO_ST_IDLE);

      // WRITE held while busy
      drive(1'b1, HILO_OP_WRITE, 1'b0, 1'b1, 32'h0, 32'h5);
      tick();
      drive(1'b1, HILO_OP_ACC_ADD, 1'b0, 1'b0, 32'h0, 32'h1);
      tick();
      drive(1'b1, HILO_OP_WRITE, 1'b0, 1'b1, 32'hDEAD, 32'hA5);
      #1;
      chk("hold_ready_lo", bus.ready_o, 0);
      tick();
      #1;
      chk("hold_done", bus.done_o, 1);
      chk("hold_lo_busy", bus.lo_o, 32'h5);
      tick();
      #1;
      chk("hold_ready_idle", bus.ready_o, 1);
`ifdef HILO_WRITE_BYPASS_EN
      chk("hold_lo_bypass", bus.lo_o, 32'hA5);
`else
      chk("hold_lo_bypass", bus.lo_o, 32'h6);
`endif
      chk("hold_hi_idle", bus.hi_o, 0);
      tick();
      quiet();
      #1;
      chk("hold_lo_written", bus.lo_o, 32'hA5);
      chk("hold_hi_written", bus.hi_o, 0);
      chk("hold_state", bus.dbg_state_o, HILO_ST_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
